// File: rtl/afifo_rd_arbiter.sv
// ============================================================================
//  Module      : afifo_rd_arbiter
//  Description : Round-robin read arbiter that shares one async-FIFO read port
//                among several clients. It issues RDreq on behalf of the owner
//                and steers the returned word back with a one-hot dvalid.
//                Optional burst mode (macro AFIFO_ARB_BURST_EN) keeps a grant
//                for up to BurstLen accepted reads. Without the macro, each
//                grant moves at most one word.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module afifo_rd_arbiter #(
    parameter int Requesters = 4,
    parameter int DataWidth  = 8,
    parameter int BurstLen   = 4
) (
    input  logic                  RDclk,
    input  logic                  reset,
    input  logic [Requesters-1:0] req,
    input  logic                  FIFOempty,
    input  logic                  RDen,
    input  logic [DataWidth-1:0]  RDdata,
    output logic                  RDreq,
    output logic [Requesters-1:0] grant,
    output logic [DataWidth-1:0]  dout,
    output logic [Requesters-1:0] dvalid
);

    localparam int                IW     = $clog2(Requesters);
    localparam logic [IW:0]       C_NREQ = (IW+1)'(Requesters);
    localparam logic [IW-1:0]     C_LAST = IW'(Requesters - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // Out-of-range configurations are rejected at elaboration.
    if (Requesters < 2 || Requesters > 8 || BurstLen < 1 || BurstLen > 15) begin : g_param_check
        $error("afifo_rd_arbiter: Requesters must be 2..8 and BurstLen 1..15");
    end

    logic [0:0]            state_q, state_d;
    logic [IW-1:0]         rr_q, rr_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [IW-1:0]         tag_q, tag_d;
    logic [Requesters-1:0] grant_q, grant_d;
    logic                  pend_q, pend_d;

    logic                  w_found;
    logic [IW-1:0]         w_pick;
    logic [IW:0]           w_sum;
    logic                  w_release;
    logic                  w_leave;

`ifdef AFIFO_ARB_BURST_EN
    logic [3:0]            cnt_q, cnt_d;

    // The grant ends once the BurstLen-th read of this grant is accepted.
    assign w_release = RDen && ((cnt_q + 4'd1) == 4'(BurstLen));

    // Burst counter is held at zero while idle, so every grant starts fresh.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = 4'd0;
        end else if (RDen) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Burst counter register.
    always_ff @(posedge RDclk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Single-word grants: the first accepted read ends the grant.
    assign w_release = RDen;
`endif

    // Leave GRANT on release, when the owner withdraws, or when the FIFO ran
    // dry and no read was accepted this cycle.
    assign w_leave = w_release || !req[owner_q] || (FIFOempty && !RDen);

    // RDreq is also masked by FIFOempty so a read is never issued on empty.
    assign RDreq  = (state_q == GRANT) && req[owner_q] && !FIFOempty;
    assign grant  = grant_q;
    assign dout   = RDdata;

    // Pick the first requester at or after rr; scanning from the far end
    // lets the nearest hit overwrite the others.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = Requesters - 1; k >= 0; k--) begin
            w_sum = {1'b0, rr_q} + (IW+1)'(k);
            if (w_sum >= C_NREQ) begin
                w_sum = w_sum - C_NREQ;
            end
            if (req[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IW-1:0];
            end
        end
    end

    // Arbitration FSM and return-path tagging.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        pend_d  = RDen;
        tag_d   = RDen ? owner_q : tag_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (w_found && !FIFOempty) begin
                    state_d         = GRANT;
                    owner_d         = w_pick;
                    grant_d[w_pick] = 1'b1;
                end
            end
            GRANT: begin
                if (w_leave) begin
                    state_d = IDLE;
                    grant_d = '0;
                    rr_d    = (owner_q == C_LAST) ? '0 : owner_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset drops grant and any pending return at once.
    always_ff @(posedge RDclk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            tag_q   <= '0;
            grant_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            tag_q   <= tag_d;
            grant_q <= grant_d;
            pend_q  <= pend_d;
        end
    end

    // Returned word is flagged for the client that owned the read.
    always_comb begin
        dvalid = '0;
        if (pend_q) begin
            dvalid[tag_q] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_afifo_rd_arbiter.sv
// ============================================================================
//  Module      : tb_afifo_rd_arbiter
//  Description : Self-checking bench for afifo_rd_arbiter: vector table,
//                hand-written reset/round-robin/burst sequences and a random
//                run against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_afifo_rd_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
`ifdef AFIFO_ARB_BURST_EN
    localparam int BL = 4;
`else
    localparam int BL = 1;
`endif

    logic          RDclk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req = '0;
    logic          FIFOempty = 1'b1;
    logic          RDen = 1'b0;
    logic [DW-1:0] RDdata = '0;
    logic          RDreq;
    logic [N-1:0]  grant;
    logic [DW-1:0] dout;
    logic [N-1:0]  dvalid;

    always #5 RDclk = ~RDclk;

    afifo_rd_arbiter #(
        .Requesters (N),
        .DataWidth  (DW),
        .BurstLen   (4)
    ) u_dut (
        .RDclk     (RDclk),
        .reset     (reset),
        .req       (req),
        .FIFOempty (FIFOempty),
        .RDen      (RDen),
        .RDdata    (RDdata),
        .RDreq     (RDreq),
        .grant     (grant),
        .dout      (dout),
        .dvalid    (dvalid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit            m_gr;
    int            m_owner, m_rr, m_cnt, m_tag;
    bit            m_pend;
    logic [DW-1:0] m_data;
    logic [DW-1:0] fifo[$];

    task automatic model_reset();
        m_gr = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_tag = 0; m_pend = 0;
        m_data = '0;
        fifo.delete();
    endtask

    // One clock of the arbiter rules, applied to the inputs seen at the edge.
    task automatic model_step();
        bit rd;
        bit leave;
        bit found;
        int old_owner;
        int c2;
        rd = RDen;
        old_owner = m_owner;
        if (m_gr) begin
            c2 = m_cnt + (rd ? 1 : 0);
            leave = (rd && c2 >= BL) || !req[m_owner] || (FIFOempty && !rd);
            if (leave) begin
                m_gr = 0;
                m_rr = (m_owner + 1) % N;
            end else begin
                m_cnt = c2;
            end
        end else if (req != 0 && !FIFOempty) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_rr + k) % N]) begin
                    found = 1;
                    m_owner = (m_rr + k) % N;
                end
            end
            m_gr = 1;
            m_cnt = 0;
        end
        m_pend = rd;
        if (rd) m_tag = old_owner;
    endtask

    // One cycle: drive at negedge, check RDreq, clock, check registered outputs.
    task automatic run_cycle(input logic [N-1:0] r, input bit acc, input bit push_ok);
        logic          exp_rdreq;
        logic [N-1:0]  eg;
        logic [N-1:0]  ev;
        req = r;
        FIFOempty = (fifo.size() == 0);
        exp_rdreq = m_gr && req[m_owner] && !FIFOempty;
        RDen = exp_rdreq && acc;
        #1;
        chk("rdreq", {31'd0, RDreq}, {31'd0, exp_rdreq});
        @(posedge RDclk);
        model_step();
        if (RDen) begin
            m_data = fifo.pop_front();
            RDdata = m_data;
        end
        if (push_ok && fifo.size() < 6 && $urandom_range(0, 1) == 1)
            fifo.push_back(DW'($urandom));
        @(negedge RDclk);
        eg = '0;
        if (m_gr) eg[m_owner] = 1'b1;
        ev = '0;
        if (m_pend) ev[m_tag] = 1'b1;
        chk("grant", {28'd0, grant}, {28'd0, eg});
        chk("dvalid", {28'd0, dvalid}, {28'd0, ev});
        chk("onehot", {31'd0, $onehot0(grant) && $onehot0(dvalid)}, 32'd1);
        if (m_pend) chk("dout", {24'd0, dout}, {24'd0, m_data});
    endtask

    task automatic do_reset();
        reset = 1'b0; req = '0; FIFOempty = 1'b1; RDen = 1'b0;
        @(negedge RDclk);
        @(negedge RDclk);
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] req;
        logic         empty;
        logic         rden;
        logic         exp_rdreq;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_dvalid;
    } vec_t;

    vec_t tbl[13];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [N-1:0] glog[$];
        logic [N-1:0] dlog[$];
        logic [N-1:0] prev;
        logic [N-1:0] exp_rr[5];
        logic [N-1:0] exp_bu[10];
        logic [N-1:0] r;

        // idle-start sequence covering empty, early drop and wrap of rr
        tbl[0]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000};
        tbl[3]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000};
        tbl[4]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b1010, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b0000};
        tbl[6]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000};
        tbl[8]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0011, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000};
        tbl[10] = '{4'b0011, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0000};
        tbl[11] = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0011, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000};

        // Held in reset with every client requesting: nothing may move.
        @(negedge RDclk);
        req = 4'b1111; FIFOempty = 1'b0; RDen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rst_grant", {28'd0, grant}, 32'd0);
            chk("rst_rdreq", {31'd0, RDreq}, 32'd0);
            chk("rst_dvalid", {28'd0, dvalid}, 32'd0);
            @(negedge RDclk);
        end
        req = '0; FIFOempty = 1'b1;
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            req = tbl[i].req; FIFOempty = tbl[i].empty; RDen = tbl[i].rden;
            #1;
            chk($sformatf("tbl%0d_rdreq", i), {31'd0, RDreq}, {31'd0, tbl[i].exp_rdreq});
            @(negedge RDclk);
            chk($sformatf("tbl%0d_grant", i), {28'd0, grant}, {28'd0, tbl[i].exp_grant});
            chk($sformatf("tbl%0d_dvalid", i), {28'd0, dvalid}, {28'd0, tbl[i].exp_dvalid});
        end

        // Reset during a pending return and during a held grant.
        do_reset();
        req = 4'b0011; FIFOempty = 1'b0; RDen = 1'b0;
        @(negedge RDclk);
        chk("mr_grant", {28'd0, grant}, 32'h1);
        RDen = 1'b1;
        #1 chk("mr_rdreq", {31'd0, RDreq}, 32'd1);
        @(negedge RDclk);
        RDen = 1'b0;
        chk("mr_dvalid_pre", {28'd0, dvalid}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("mr_grant_drop", {28'd0, grant}, 32'd0);
        chk("mr_dvalid_drop", {28'd0, dvalid}, 32'd0);
        chk("mr_rdreq_drop", {31'd0, RDreq}, 32'd0);
        @(negedge RDclk);
        chk("mr_dvalid_held", {28'd0, dvalid}, 32'd0);
        reset = 1'b1;
        @(negedge RDclk);
        chk("mr_restart", {28'd0, grant}, 32'h1);
        #1 chk("mr_restart_rdreq", {31'd0, RDreq}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mr2_grant_drop", {28'd0, grant}, 32'd0);
        chk("mr2_rdreq_drop", {31'd0, RDreq}, 32'd0);
        @(negedge RDclk);
        reset = 1'b1;

        do_reset();
        model_reset();
`ifdef AFIFO_ARB_BURST_EN
        // Two clients, ten words, four-word bursts.
        exp_bu = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                   4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
        for (int i = 0; i < 10; i++) fifo.push_back(DW'(8'h30 + i));
        for (int c = 0; c < 40; c++) begin
            run_cycle(4'b0011, 1'b1, 1'b0);
            if (dvalid != 0) dlog.push_back(dvalid);
        end
        chk("burst_count", dlog.size(), 32'd10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("burst_dv%0d", i), {28'd0, (i < dlog.size()) ? dlog[i] : 4'b0}, {28'd0, exp_bu[i]});
        chk("burst_idle", {28'd0, grant}, 32'd0);
`else
        // All four clients, eight words, single-word grants.
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 8; i++) fifo.push_back(DW'(8'hA0 + i));
        prev = '0;
        for (int c = 0; c < 30; c++) begin
            run_cycle(4'b1111, 1'b1, 1'b0);
            if (grant != 0 && prev == 0) glog.push_back(grant);
            if (dvalid != 0) dlog.push_back(dvalid);
            prev = grant;
        end
        chk("rr_grants", glog.size(), 32'd8);
        chk("rr_dvalids", dlog.size(), 32'd8);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_seq%0d", i), {28'd0, (i < glog.size()) ? glog[i] : 4'b0}, {28'd0, exp_rr[i]});
`endif

        // Randomised traffic against the model.
        do_reset();
        model_reset();
        r = 4'b1111;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
            run_cycle(r, $urandom_range(0, 3) != 0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
